prog_timer: RTL and testbench

//  Parametrised programmable down-counter/timer; successor to the fixed 4-bit count-down-from-9 counter.

---
 rtl/timer_pkg.sv | 15 +
 rtl/clk_prescaler.sv | 39 +++
 rtl/prog_timer.sv | 131 +++++++++++++
 tb/tb_prog_timer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared state and mode encodings for the programmable timer.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } timer_state_t;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } timer_mode_t;

endpackage

// File: rtl/clk_prescaler.sv
// Clock-enable divider: ce is high on one clock out of every DIV enabled clocks.
// With DIV=1 the enable passes straight through and no counter exists.
module clk_prescaler #(
  parameter int DIV = 1
) (
  input  logic clk50m,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic ce
);

  if (DIV == 1) begin : g_bypass
    logic w_unused;
    assign w_unused = &{1'b0, clk50m, rst_n, clr};
    assign ce = en;
  end else begin : g_div
    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] r_pre;

    assign ce = en && (r_pre == LAST);

    // Phase counter: frozen when not enabled, cleared on clr, wraps after LAST.
    always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
        r_pre <= '0;
      end else if (clr) begin
        r_pre <= '0;
      end else if (en) begin
        r_pre <= (r_pre == LAST) ? '0 : r_pre + PW'(1);
      end else begin
        r_pre <= r_pre;
      end
    end
  end

endmodule

// File: rtl/prog_timer.sv
// Programmable down-counter/timer with reload, one-shot/periodic modes,
// start/stop/hold control and a clock-enable prescaler. All outputs registered.
module prog_timer #(
  parameter int WIDTH        = 4,
  parameter int PRESCALE_DIV = 1,
  parameter int RST_VAL      = 9,
  parameter int AUTO_START   = 0
) (
  input  logic             clk50m,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             mode,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             cnt_zero,
  output logic             tick,
  output logic             done,
  output logic             busy
);
  import timer_pkg::*;

  if (WIDTH < 2) begin : g_chk_width
    $error("prog_timer: WIDTH must be >= 2");
  end
  if (PRESCALE_DIV < 1) begin : g_chk_div
    $error("prog_timer: PRESCALE_DIV must be >= 1");
  end
  if (RST_VAL < 0 || RST_VAL >= (1 << WIDTH)) begin : g_chk_rst
    $error("prog_timer: RST_VAL must fit in WIDTH bits");
  end

  localparam logic [WIDTH-1:0] RST_CNT   = WIDTH'(RST_VAL);
  localparam timer_state_t     RST_STATE = (AUTO_START != 0) ? ST_RUN : ST_IDLE;
  localparam logic             RST_BUSY  = (AUTO_START != 0);
  localparam logic             RST_ZERO  = (RST_VAL == 0);

  timer_state_t     r_state, w_state_nxt;
  timer_mode_t      r_mode, w_mode_nxt;
  logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_reload, w_reload_nxt;
  logic             r_tick, w_tick_nxt;
  logic             r_done, w_done_nxt;
  logic             r_zero, r_busy;
  logic             w_ce, w_pre_en, w_pre_clr;

  // The prescaler advances only on edges that actually count: PAUSE resumes on
  // the edge hold is seen low, so a hold of K clocks stretches the period by K.
  assign w_pre_en  = !stop && !start && !hold && (r_state != ST_IDLE);
  assign w_pre_clr = start && !stop;

  clk_prescaler #(
    .DIV (PRESCALE_DIV)
  ) u_prescaler (
    .clk50m (clk50m),
    .rst_n  (rst_n),
    .en     (w_pre_en),
    .clr    (w_pre_clr),
    .ce     (w_ce)
  );

  // Next-state and counter decisions, priority stop > start > hold > count.
  always_comb begin
    w_state_nxt  = r_state;
    w_mode_nxt   = r_mode;
    w_cnt_nxt    = r_cnt;
    w_reload_nxt = r_reload;
    w_tick_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    if (stop) begin
      w_state_nxt = ST_IDLE;
    end else if (start) begin
      w_cnt_nxt    = load_val;
      w_reload_nxt = load_val;
      w_mode_nxt   = timer_mode_t'(mode);
      w_state_nxt  = hold ? ST_PAUSE : ST_RUN;
    end else if (r_state == ST_IDLE) begin
      w_state_nxt = ST_IDLE;
    end else if (hold) begin
      w_state_nxt = ST_PAUSE;
    end else begin
      w_state_nxt = ST_RUN;
      if (w_ce) begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - WIDTH'(1);
        end else begin
          w_tick_nxt = 1'b1;
          if (r_mode == MODE_PERIODIC) begin
            w_cnt_nxt = r_reload;
          end else begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end else begin
        w_cnt_nxt = r_cnt;
      end
    end
  end

  // State, counter and registered status outputs.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RST_STATE;
      r_mode   <= MODE_PERIODIC;
      r_cnt    <= RST_CNT;
      r_reload <= RST_CNT;
      r_tick   <= 1'b0;
      r_done   <= 1'b0;
      r_zero   <= RST_ZERO;
      r_busy   <= RST_BUSY;
    end else begin
      r_state  <= w_state_nxt;
      r_mode   <= w_mode_nxt;
      r_cnt    <= w_cnt_nxt;
      r_reload <= w_reload_nxt;
      r_tick   <= w_tick_nxt;
      r_done   <= w_done_nxt;
      r_zero   <= (w_cnt_nxt == '0);
      r_busy   <= (w_state_nxt != ST_IDLE);
    end
  end

  assign cnt      = r_cnt;
  assign cnt_zero = r_zero;
  assign tick     = r_tick;
  assign done     = r_done;
  assign busy     = r_busy;

endmodule

// File: tb/tb_prog_timer.sv
// Self-checking bench for prog_timer: four parameterisations share stimulus;
// each scenario queues expected samples and pops them as clocks advance.
module tb_prog_timer;

  typedef struct packed {
    logic [7:0] cnt;
    logic       tick;
    logic       done;
    logic       busy;
    logic       zero;
  } smp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       hold = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] load_val = 8'd0;

  logic [3:0] a_cnt, u_cnt, d_cnt;
  logic [7:0] w_cnt;
  logic a_zero, a_tick, a_done, a_busy;
  logic u_zero, u_tick, u_done, u_busy;
  logic d_zero, d_tick, d_done, d_busy;
  logic w_zero, w_tick, w_done, w_busy;

  int   total = 0;
  int   bad = 0;
  smp_t exp_q[$];

  always #10 clk = ~clk;

  prog_timer #(.WIDTH(4), .PRESCALE_DIV(1), .RST_VAL(9), .AUTO_START(0)) dut_a (
    .clk50m(clk), .rst_n(rst_n), .start(start), .stop(stop), .hold(hold), .mode(mode),
    .load_val(load_val[3:0]), .cnt(a_cnt), .cnt_zero(a_zero), .tick(a_tick), .done(a_done), .busy(a_busy));

  prog_timer #(.WIDTH(4), .PRESCALE_DIV(1), .RST_VAL(9), .AUTO_START(1)) dut_auto (
    .clk50m(clk), .rst_n(rst_n), .start(start), .stop(stop), .hold(hold), .mode(mode),
    .load_val(load_val[3:0]), .cnt(u_cnt), .cnt_zero(u_zero), .tick(u_tick), .done(u_done), .busy(u_busy));

  prog_timer #(.WIDTH(4), .PRESCALE_DIV(4), .RST_VAL(9), .AUTO_START(0)) dut_d4 (
    .clk50m(clk), .rst_n(rst_n), .start(start), .stop(stop), .hold(hold), .mode(mode),
    .load_val(load_val[3:0]), .cnt(d_cnt), .cnt_zero(d_zero), .tick(d_tick), .done(d_done), .busy(d_busy));

  prog_timer #(.WIDTH(8), .PRESCALE_DIV(1), .RST_VAL(9), .AUTO_START(0)) dut_w8 (
    .clk50m(clk), .rst_n(rst_n), .start(start), .stop(stop), .hold(hold), .mode(mode),
    .load_val(load_val), .cnt(w_cnt), .cnt_zero(w_zero), .tick(w_tick), .done(w_done), .busy(w_busy));

  function automatic smp_t mk(input logic [7:0] c, input logic t, input logic d,
                              input logic b, input logic z);
    return {c, t, d, b, z};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    smp_t e, o;
    exp_q.push_back(mk(8'd9, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(8'd9, 1'b0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(8'd9, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(8'd9, 1'b0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b0;
    step();
    step();
    e = exp_q.pop_front(); o = {4'd0, a_cnt, a_tick, a_done, a_busy, a_zero}; total++;
    if (o !== e) begin bad++; $display("FAIL reset_a got=%h exp=%h", o, e); end
    e = exp_q.pop_front(); o = {4'd0, u_cnt, u_tick, u_done, u_busy, u_zero}; total++;
    if (o !== e) begin bad++; $display("FAIL reset_auto got=%h exp=%h", o, e); end
    e = exp_q.pop_front(); o = {4'd0, d_cnt, d_tick, d_done, d_busy, d_zero}; total++;
    if (o !== e) begin bad++; $display("FAIL reset_d4 got=%h exp=%h", o, e); end
    e = exp_q.pop_front(); o = {w_cnt, w_tick, w_done, w_busy, w_zero}; total++;
    if (o !== e) begin bad++; $display("FAIL reset_w8 got=%h exp=%h", o, e); end
    rst_n = 1'b1;
  endtask

  // Legacy free-running count 9..0 with a tick every 10 clocks.
  task automatic test_auto_start();
    smp_t e, o;
    for (int k = 0; k <= 25; k++) begin
      exp_q.push_back(mk(8'(9 - (k % 10)), (k > 0) && (k % 10 == 0), 1'b0, 1'b1, (k % 10 == 9)));
    end
    for (int k = 0; k <= 25; k++) begin
      if (k > 0) step();
      e = exp_q.pop_front(); o = {4'd0, u_cnt, u_tick, u_done, u_busy, u_zero}; total++;
      if (o !== e) begin bad++; $display("FAIL auto_start k=%0d got=%h exp=%h", k, o, e); end
    end
  endtask

  task automatic test_oneshot();
    smp_t e, o;
    for (int j = 0; j <= 15; j++) begin
      exp_q.push_back(mk((j <= 5) ? 8'(5 - j) : 8'd0, (j == 6), (j == 6), (j <= 5), (j >= 5)));
    end
    mode = 1'b0; load_val = 8'd5; start = 1'b1;
    for (int j = 0; j <= 15; j++) begin
      step();
      if (j == 0) start = 1'b0;
      e = exp_q.pop_front(); o = {4'd0, a_cnt, a_tick, a_done, a_busy, a_zero}; total++;
      if (o !== e) begin bad++; $display("FAIL oneshot j=%0d got=%h exp=%h", j, o, e); end
    end
  endtask

  // DIV=4, reload 2: 12-clock period; 8 clocks of hold shift later ticks by 8.
  task automatic test_prescale_hold();
    smp_t e, o;
    int t;
    logic frz;
    logic [7:0] c;
    for (int j = 0; j <= 50; j++) begin
      frz = (j >= 31) && (j <= 38);
      t = (j <= 30) ? j : (frz ? 30 : j - 8);
      c = 8'(2 - ((t % 12) / 4));
      exp_q.push_back(mk(c, !frz && (t > 0) && (t % 12 == 0), 1'b0, 1'b1, (c == 8'd0)));
    end
    mode = 1'b1; load_val = 8'd2; start = 1'b1;
    for (int j = 0; j <= 50; j++) begin
      step();
      if (j == 0) start = 1'b0;
      if (j == 30) hold = 1'b1;
      if (j == 38) hold = 1'b0;
      e = exp_q.pop_front(); o = {4'd0, d_cnt, d_tick, d_done, d_busy, d_zero}; total++;
      if (o !== e) begin bad++; $display("FAIL prescale_hold j=%0d got=%h exp=%h", j, o, e); end
    end
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic test_restart_collision();
    smp_t e, o;
    exp_q.push_back(mk(8'd2, 1'b0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(8'd1, 1'b0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(8'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    exp_q.push_back(mk(8'd3, 1'b0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(8'd2, 1'b0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(8'd1, 1'b0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(8'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    exp_q.push_back(mk(8'd3, 1'b1, 1'b0, 1'b1, 1'b0));
    for (int j = 8; j <= 11; j++) exp_q.push_back(mk(8'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    mode = 1'b1; load_val = 8'd2; start = 1'b1;
    for (int j = 0; j <= 11; j++) begin
      step();
      case (j)
        0: start = 1'b0;
        2: begin start = 1'b1; load_val = 8'd3; end
        3: start = 1'b0;
        7: begin start = 1'b1; stop = 1'b1; load_val = 8'd7; end
        8: begin start = 1'b0; stop = 1'b0; end
        default: ;
      endcase
      e = exp_q.pop_front(); o = {4'd0, a_cnt, a_tick, a_done, a_busy, a_zero}; total++;
      if (o !== e) begin bad++; $display("FAIL restart_collision j=%0d got=%h exp=%h", j, o, e); end
    end
  endtask

  task automatic test_zero_reload();
    smp_t e, o;
    for (int j = 0; j <= 8; j++) exp_q.push_back(mk(8'd0, (j >= 1), 1'b0, 1'b1, 1'b1));
    mode = 1'b1; load_val = 8'd0; start = 1'b1;
    for (int j = 0; j <= 8; j++) begin
      step();
      if (j == 0) start = 1'b0;
      e = exp_q.pop_front(); o = {4'd0, a_cnt, a_tick, a_done, a_busy, a_zero}; total++;
      if (o !== e) begin bad++; $display("FAIL zero_reload j=%0d got=%h exp=%h", j, o, e); end
    end
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic test_wide_period();
    smp_t e, o;
    for (int j = 0; j <= 520; j++) begin
      exp_q.push_back(mk(8'(255 - (j % 256)), (j > 0) && (j % 256 == 0), 1'b0, 1'b1, (j % 256 == 255)));
    end
    mode = 1'b1; load_val = 8'd255; start = 1'b1;
    for (int j = 0; j <= 520; j++) begin
      step();
      if (j == 0) start = 1'b0;
      e = exp_q.pop_front(); o = {w_cnt, w_tick, w_done, w_busy, w_zero}; total++;
      if (o !== e) begin bad++; $display("FAIL wide_period j=%0d got=%h exp=%h", j, o, e); end
    end
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  // Reset asserted between edges while a tick is high must clear it at once.
  task automatic test_async_reset();
    smp_t e, o;
    exp_q.push_back(mk(8'd2, 1'b0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(8'd1, 1'b0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(8'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    exp_q.push_back(mk(8'd2, 1'b1, 1'b0, 1'b1, 1'b0));
    for (int j = 0; j < 3; j++) exp_q.push_back(mk(8'd9, 1'b0, 1'b0, 1'b0, 1'b0));
    mode = 1'b1; load_val = 8'd2; start = 1'b1;
    for (int j = 0; j <= 3; j++) begin
      step();
      if (j == 0) start = 1'b0;
      e = exp_q.pop_front(); o = {4'd0, a_cnt, a_tick, a_done, a_busy, a_zero}; total++;
      if (o !== e) begin bad++; $display("FAIL async_pre j=%0d got=%h exp=%h", j, o, e); end
    end
    #5 rst_n = 1'b0;
    #1;
    e = exp_q.pop_front(); o = {4'd0, a_cnt, a_tick, a_done, a_busy, a_zero}; total++;
    if (o !== e) begin bad++; $display("FAIL async_immediate got=%h exp=%h", o, e); end
    step();
    e = exp_q.pop_front(); o = {4'd0, a_cnt, a_tick, a_done, a_busy, a_zero}; total++;
    if (o !== e) begin bad++; $display("FAIL async_held got=%h exp=%h", o, e); end
    rst_n = 1'b1;
    step();
    e = exp_q.pop_front(); o = {4'd0, a_cnt, a_tick, a_done, a_busy, a_zero}; total++;
    if (o !== e) begin bad++; $display("FAIL async_release got=%h exp=%h", o, e); end
  endtask

  initial begin
    test_reset();
    test_auto_start();
    test_oneshot();
    test_prescale_hold();
    test_restart_collision();
    test_zero_reload();
    test_wide_period();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
